// File: rtl/decode_hazard_controller.sv
// Decode-stage hazard controller: two-entry EX/MEM write scoreboard, RAW stall
// insertion, and fetch hold while an issued BEQ is being resolved by the datapath.
module decode_hazard_controller #(
  parameter bit FORWARDING = 1'b1,
  parameter int BR_TIMEOUT = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             branch_done,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] branch_count,
  output logic             br_timeout_err
);

  localparam int                TMR_W    = $clog2(BR_TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(BR_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef struct packed {
    logic       vld;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;

  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  sb_entry_t        ex_q, ex_d, mem_q, mem_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic             br_timeout_err_q, br_timeout_err_d;

  logic [4:0] rs, rt, rd;
  logic       reads_rt, is_beq, stall, issued;
  sb_entry_t  id_ent;
  logic       unused_imm;

  assign rs = id_instr[25:21];
  assign rt = id_instr[20:16];
  assign rd = id_instr[15:11];
  assign unused_imm = ^id_instr[10:0];

  // Stores and branches leave dest at 0, which doubles as "no write".
  always_comb begin
    reads_rt       = 1'b0;
    is_beq         = 1'b0;
    id_ent         = '0;
    case (id_instr[31:26])
      OP_RTYPE: begin reads_rt = 1'b1; id_ent.dest = rd; end
      OP_LW:    begin id_ent.dest = rt; id_ent.is_load = 1'b1; end
      OP_SW:    reads_rt = 1'b1;
      OP_BEQ:   begin reads_rt = 1'b1; is_beq = 1'b1; end
      default:  id_ent.dest = rt;
    endcase
    id_ent.vld = (id_ent.dest != 5'd0);
  end

  function automatic logic src_hit(input logic [4:0] src, input sb_entry_t ex,
                                   input sb_entry_t mem);
    logic ex_hit, mem_hit;
    ex_hit  = ex.vld  && (ex.dest  == src);
    mem_hit = mem.vld && (mem.dest == src);
    if (src == 5'd0)     return 1'b0;
    else if (FORWARDING) return ex_hit && ex.is_load;
    else                 return ex_hit || mem_hit;
  endfunction

  assign stall  = id_valid && (state_q == RUN) &&
                  (src_hit(rs, ex_q, mem_q) || (reads_rt && src_hit(rt, ex_q, mem_q)));
  assign issued = id_valid && !stall && (state_q == RUN);

  assign ex_d  = issued ? id_ent : '0;
  assign mem_d = ex_q;

  always_comb begin
    state_d          = state_q;
    timer_d          = timer_q;
    stall_cycles_d   = stall_cycles_q;
    branch_count_d   = branch_count_q;
    br_timeout_err_d = br_timeout_err_q;
    pc_write         = 1'b1;
    ifid_write       = 1'b1;
    ifid_flush       = 1'b0;
    idex_bubble      = ~id_valid;
    case (state_q)
      RUN: begin
        if (stall) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + 1'b1;
        end else if (issued && is_beq) begin
          pc_write       = 1'b0;
          ifid_flush     = 1'b1;
          idex_bubble    = 1'b0;
          branch_count_d = branch_count_q + 1'b1;
          state_d        = BR_WAIT;
          timer_d        = '0;
        end
      end
      BR_WAIT: begin
        idex_bubble = 1'b1;
        ifid_flush  = 1'b1;
        pc_write    = branch_done;
        // A resolve arriving on the last allowed cycle still counts as on time.
        if (branch_done) begin
          state_d = RUN;
        end else if (timer_q == TMR_LAST) begin
          br_timeout_err_d = 1'b1;
          state_d          = RUN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= RUN;
      timer_q          <= '0;
      ex_q             <= '0;
      mem_q            <= '0;
      stall_cycles_q   <= '0;
      branch_count_q   <= '0;
      br_timeout_err_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      ex_q             <= ex_d;
      mem_q            <= mem_d;
      stall_cycles_q   <= stall_cycles_d;
      branch_count_q   <= branch_count_d;
      br_timeout_err_q <= br_timeout_err_d;
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign branch_count   = branch_count_q;
  assign br_timeout_err = br_timeout_err_q;

endmodule

// File: tb/tb_decode_hazard_controller.sv
// Bench for decode_hazard_controller: one forwarding and one non-forwarding instance
// share stimulus; a register-age model checks both every cycle, plus literal pins.
module tb_decode_hazard_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic        branch_done = 1'b0;
  logic [31:0] id_instr = '0;

  logic [1:0]  pc_write, ifid_write, ifid_flush, idex_bubble, err;
  logic [15:0] stc_o [2];
  logic [15:0] brc_o [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_hazard_controller #(.FORWARDING(1'b1), .BR_TIMEOUT(8), .CNT_W(16)) u_fwd (
    .clk(clk), .reset(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .branch_done(branch_done), .pc_write(pc_write[0]), .ifid_write(ifid_write[0]),
    .ifid_flush(ifid_flush[0]), .idex_bubble(idex_bubble[0]), .stall_cycles(stc_o[0]),
    .branch_count(brc_o[0]), .br_timeout_err(err[0]));

  decode_hazard_controller #(.FORWARDING(1'b0), .BR_TIMEOUT(8), .CNT_W(16)) u_nof (
    .clk(clk), .reset(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .branch_done(branch_done), .pc_write(pc_write[1]), .ifid_write(ifid_write[1]),
    .ifid_flush(ifid_flush[1]), .idex_bubble(idex_bubble[1]), .stall_cycles(stc_o[1]),
    .branch_count(brc_o[1]), .br_timeout_err(err[1]));

  // Model: per register, the cycle its latest in-flight writer issued and whether it was a load.
  int wcyc  [2][32];
  bit wload [2][32];
  bit m_bw  [2];
  int m_tmr [2];
  int m_stc [2];
  int m_brc [2];
  bit m_err [2];
  int cyc = 0;

  function automatic void decode(input logic [31:0] ins, output bit rd_rt, output int dst,
                                 output bit ld, output bit beq);
    rd_rt = 0; dst = 0; ld = 0; beq = 0;
    case (ins[31:26])
      6'b000000: begin rd_rt = 1; dst = int'(ins[15:11]); end
      6'b100011: begin dst = int'(ins[20:16]); ld = 1; end
      6'b101011: rd_rt = 1;
      6'b000100: begin rd_rt = 1; beq = 1; end
      default:   dst = int'(ins[20:16]);
    endcase
  endfunction

  function automatic bit haz(input int k, input int r);
    if (r == 0) return 0;
    if (k == 0) return (wcyc[k][r] == cyc - 1) && wload[k][r];
    return wcyc[k][r] >= cyc - 2;
  endfunction

  function automatic void expect_out(input int k, output bit st, output bit e_pw,
                                     output bit e_iw, output bit e_fl, output bit e_bb);
    bit rd_rt, ld, beq;
    int dst;
    decode(id_instr, rd_rt, dst, ld, beq);
    st = 0; e_pw = 1; e_iw = 1; e_fl = 0; e_bb = !id_valid;
    if (m_bw[k]) begin
      e_pw = branch_done; e_fl = 1; e_bb = 1;
    end else begin
      st = id_valid && (haz(k, int'(id_instr[25:21])) || (rd_rt && haz(k, int'(id_instr[20:16]))));
      if (st) begin
        e_pw = 0; e_iw = 0; e_bb = 1;
      end else if (id_valid && beq) begin
        e_pw = 0; e_fl = 1; e_bb = 0;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < 32; r++) begin wcyc[k][r] <= -100; wload[k][r] <= 0; end
        m_bw[k] <= 0; m_tmr[k] <= 0; m_stc[k] <= 0; m_brc[k] <= 0; m_err[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit st, pw, iw, fl, bb, rd_rt, ld, beq;
        int dst;
        expect_out(k, st, pw, iw, fl, bb);
        decode(id_instr, rd_rt, dst, ld, beq);
        if (st && m_stc[k] < 65535) m_stc[k] <= m_stc[k] + 1;
        if (!m_bw[k]) begin
          if (id_valid && !st) begin
            if (dst != 0) begin wcyc[k][dst] <= cyc; wload[k][dst] <= ld; end
            if (beq) begin m_brc[k] <= m_brc[k] + 1; m_bw[k] <= 1; m_tmr[k] <= 0; end
          end
        end else if (branch_done) begin
          m_bw[k] <= 0;
        end else if (m_tmr[k] == 7) begin
          m_err[k] <= 1; m_bw[k] <= 0;
        end else begin
          m_tmr[k] <= m_tmr[k] + 1;
        end
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit st, pw, iw, fl, bb;
      expect_out(k, st, pw, iw, fl, bb);
      total++;
      if ({pc_write[k], ifid_write[k], ifid_flush[k], idex_bubble[k], err[k]} !==
          {pw, iw, fl, bb, m_err[k]} || stc_o[k] !== 16'(m_stc[k]) || brc_o[k] !== 16'(m_brc[k])) begin
        bad++;
        $display("FAIL model dut%0d t=%0t: pw,iw,fl,bb,err=%b%b%b%b%b stc=%0d brc=%0d; want %b%b%b%b%b stc=%0d brc=%0d",
                 k, $time, pc_write[k], ifid_write[k], ifid_flush[k], idex_bubble[k], err[k],
                 stc_o[k], brc_o[k], pw, iw, fl, bb, m_err[k], 16'(m_stc[k]), 16'(m_brc[k]));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic apply(input bit v, input logic [31:0] ins, input bit bd);
    @(posedge clk);
    #1;
    id_valid = v; id_instr = ins; branch_done = bd;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'b000000, s, t, d, 5'd0, 6'h22};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                        input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  initial begin
    logic [31:0] beq_i;
    beq_i = itype(6'b000100, 5'd0, 5'd30, 16'd16);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    apply(0, '0, 0);
    chk("rst_pc_write", pc_write[0], 1);
    chk("rst_ifid_write", ifid_write[0], 1);
    chk("rst_idex_bubble", idex_bubble[0], 1);
    chk("rst_ifid_flush", ifid_flush[0], 0);
    chk("rst_stall_cycles", stc_o[0], 0);
    chk("rst_branch_count", brc_o[0], 0);

    // Load-use: LW $21,(…$31) then SUB reading $21.
    apply(1, itype(6'b100011, 5'd31, 5'd21, 16'd0), 0);
    apply(1, rtype(5'd21, 5'd31, 5'd0), 0);
    chk("lu_fwd_pc_write", pc_write[0], 0);
    chk("lu_fwd_bubble", idex_bubble[0], 1);
    chk("lu_fwd_ifid_write", ifid_write[0], 0);
    apply(1, rtype(5'd21, 5'd31, 5'd0), 0);
    chk("lu_fwd_resume", pc_write[0], 1);
    chk("lu_fwd_stall_cycles", stc_o[0], 1);
    chk("lu_nof_still_stall", pc_write[1], 0);
    apply(1, rtype(5'd21, 5'd31, 5'd0), 0);
    chk("lu_nof_resume", pc_write[1], 1);
    chk("lu_nof_stall_cycles", stc_o[1], 2);
    repeat (3) apply(0, '0, 0);

    // ALU-ALU dependency through $3.
    apply(1, rtype(5'd1, 5'd2, 5'd3), 0);
    apply(1, rtype(5'd3, 5'd4, 5'd5), 0);
    chk("raw_nof_stall1", pc_write[1], 0);
    apply(1, rtype(5'd3, 5'd4, 5'd5), 0);
    chk("raw_nof_stall2", pc_write[1], 0);
    apply(1, rtype(5'd3, 5'd4, 5'd5), 0);
    chk("raw_nof_resume", pc_write[1], 1);
    chk("raw_nof_stall_cycles", stc_o[1], 4);
    chk("raw_fwd_no_stall", stc_o[0], 1);
    repeat (3) apply(0, '0, 0);

    // Writes to $0 never create a hazard.
    apply(1, rtype(5'd1, 5'd2, 5'd0), 0);
    apply(1, rtype(5'd0, 5'd4, 5'd5), 0);
    chk("r0_nof_no_stall", pc_write[1], 1);
    apply(0, '0, 0);
    chk("r0_nof_stall_cycles", stc_o[1], 4);
    repeat (2) apply(0, '0, 0);

    // BEQ resolved on the third BR_WAIT cycle.
    apply(1, beq_i, 0);
    chk("beq_issue_flush", ifid_flush[0], 1);
    chk("beq_issue_pc_write", pc_write[0], 0);
    chk("beq_issue_bubble", idex_bubble[0], 0);
    apply(0, '0, 0);
    chk("bw1_flush", ifid_flush[0], 1);
    chk("bw1_pc_write", pc_write[0], 0);
    chk("bw1_branch_count", brc_o[0], 1);
    apply(0, '0, 0);
    apply(0, '0, 1);
    chk("bw3_pc_pulse", pc_write[0], 1);
    apply(0, '0, 0);
    chk("beq_run_flush", ifid_flush[0], 0);
    chk("beq_run_pc_write", pc_write[0], 1);

    // Resolve arriving on the final allowed cycle: no error.
    apply(1, beq_i, 0);
    repeat (7) apply(0, '0, 0);
    apply(0, '0, 1);
    chk("edge_pc_pulse", pc_write[0], 1);
    apply(0, '0, 0);
    chk("edge_no_err", err[0], 0);
    chk("edge_flush_off", ifid_flush[0], 0);

    // Timeout: eight BR_WAIT cycles without resolve.
    apply(1, beq_i, 0);
    repeat (8) apply(0, '0, 0);
    chk("to_last_flush", ifid_flush[0], 1);
    chk("to_last_err", err[0], 0);
    apply(0, '0, 0);
    chk("to_err_set", err[0], 1);
    chk("to_back_run", ifid_flush[0], 0);
    chk("to_branch_count", brc_o[0], 3);
    apply(0, '0, 1);
    chk("run_ignores_done", ifid_flush[0], 0);

    // Reset two cycles into BR_WAIT.
    apply(1, beq_i, 0);
    apply(0, '0, 0);
    apply(0, '0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_flush", ifid_flush[0], 0);
    chk("mid_rst_pc_write", pc_write[0], 1);
    chk("mid_rst_bubble", idex_bubble[0], 1);
    chk("mid_rst_err", err[0], 0);
    chk("mid_rst_branch_count", brc_o[0], 0);
    chk("mid_rst_stall_cycles", stc_o[1], 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset pulse while a load sits in EX must clear it.
    apply(1, itype(6'b100011, 5'd1, 5'd7, 16'd0), 0);
    @(posedge clk);
    #1 id_valid = 1'b0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    id_valid = 1'b1;
    id_instr = rtype(5'd7, 5'd0, 5'd9);
    #1;
    chk("sb_clear_fwd", pc_write[0], 1);
    chk("sb_clear_nof", pc_write[1], 1);
    apply(0, '0, 0);
    repeat (2) apply(0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
